// File: rtl/tx_uart_scheduler_if.sv
// Requester and TxUART handshake bundle for tx_uart_scheduler.
// The master side is the requesters plus the TxUART; the slave side is the scheduler.
interface tx_uart_scheduler_if #(
    parameter int NUM_REQ          = 4,
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int TX_DATA_WIDTH    = 9
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                tx_baud_clk;
    logic                                tx_enable;
    logic [TX_DATA_WIDTH-1:0]            tx_data;
    logic                                tx_busy;
    logic [$clog2(NUM_REQ)-1:0]          grant_id;
    logic                                frame_done;
    logic                                tx_error;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_baud_clk, tx_enable, tx_data, grant_id, frame_done, tx_error
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_baud_clk, tx_enable, tx_data, grant_id, frame_done, tx_error
    );
endinterface

// File: rtl/tx_uart_scheduler.sv
// Round-robin scheduler sharing one TxUART between NUM_REQ byte sources;
// adds parity, generates the baud tick and enforces an idle gap between frames.
//
// state     | meaning
// IDLE      | pick next requester (round robin) once TxUART is idle
// LOAD      | one-cycle tx_enable strobe, ack the granted requester
// WAIT_BUSY | wait up to 3 cycles for TxUART to report busy
// SEND      | frame on the line, wait for busy to drop
// GAP       | hold off GAP_BAUDS bit times before the next grant
module tx_uart_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_ODD       = 0,
    parameter int CLKS_PER_BAUD    = 16,
    parameter int GAP_BAUDS        = 1
) (
    input logic                 clk,
    input logic                 reset,
    tx_uart_scheduler_if.slave  bus
);
    localparam int W  = INPUT_DATA_WIDTH;
    localparam int DW = INPUT_DATA_WIDTH + PARITY_ENABLED;
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CLKS_PER_BAUD);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        SEND,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [1:0]      wait_q, wait_d;
    logic [3:0]      gap_q, gap_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            tick;
    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;
    logic [W-1:0]    win_word;
    logic [DW-1:0]   win_frame;
    logic [W-1:0]    req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign req_word[g] = bus.req_data[g*W +: W];
    end

    assign win_word = req_word[win];

    if (PARITY_ENABLED != 0) begin : g_parity
        assign win_frame = {(^win_word) ^ (PARITY_ODD != 0), win_word};
    end else begin : g_no_parity
        assign win_frame = win_word;
    end

    assign tick = (baud_q == CW'(CLKS_PER_BAUD - 1));

    // Scan from the highest offset down so the requester closest to ptr_q wins.
    always_comb begin
        win = ptr_q;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                win = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            baud_q  <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // Restarting the bit timer at LOAD aligns the first tick with the TxUART start bit.
        baud_d  = (state_q == LOAD || tick) ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid && !bus.tx_busy) begin
                    grant_d = win;
                    data_d  = win_frame;
                    ptr_d   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wait_d  = 2'd2;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = SEND;
                end else if (wait_q == 2'd0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    done_d = 1'b1;
                    if (GAP_BAUDS == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = 4'(GAP_BAUDS);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == 4'd1) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_baud_clk = tick;
    assign bus.tx_enable   = (state_q == LOAD);
    assign bus.req_ready   = (state_q == LOAD) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.tx_data     = data_q;
    assign bus.grant_id    = grant_q;
    assign bus.frame_done  = done_q;
    assign bus.tx_error    = err_q;
endmodule

// File: tb/tb_tx_uart_scheduler.sv
// Directed bench for tx_uart_scheduler: dut_a uses defaults (even parity, 1-baud gap),
// dut_b uses odd parity and a 2-baud gap. Each DUT drives a small behavioural TxUART.
module tb_tx_uart_scheduler;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DW = 9;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tx_uart_scheduler_if #(.NUM_REQ(N), .INPUT_DATA_WIDTH(W), .TX_DATA_WIDTH(DW)) bus_a ();
    tx_uart_scheduler_if #(.NUM_REQ(N), .INPUT_DATA_WIDTH(W), .TX_DATA_WIDTH(DW)) bus_b ();

    tx_uart_scheduler dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    tx_uart_scheduler #(.PARITY_ODD(1), .GAP_BAUDS(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    // Behavioural TxUART: loads {stop, data, start}, shifts one bit per baud tick.
    logic        busy_a, busy_b;
    logic        dead_a = 1'b0;
    logic [10:0] sh_a, cap_a, sh_b, cap_b;
    logic [3:0]  nb_a, nb_b;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_a <= 1'b0; nb_a <= '0; sh_a <= '0; cap_a <= '0;
        end else if (!busy_a) begin
            if (bus_a.tx_enable && !dead_a) begin
                busy_a <= 1'b1; sh_a <= {1'b1, bus_a.tx_data, 1'b0}; nb_a <= '0;
            end
        end else if (bus_a.tx_baud_clk) begin
            cap_a <= {sh_a[0], cap_a[10:1]};
            sh_a  <= sh_a >> 1;
            nb_a  <= nb_a + 1'b1;
            if (nb_a == 4'd10) busy_a <= 1'b0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_b <= 1'b0; nb_b <= '0; sh_b <= '0; cap_b <= '0;
        end else if (!busy_b) begin
            if (bus_b.tx_enable) begin
                busy_b <= 1'b1; sh_b <= {1'b1, bus_b.tx_data, 1'b0}; nb_b <= '0;
            end
        end else if (bus_b.tx_baud_clk) begin
            cap_b <= {sh_b[0], cap_b[10:1]};
            sh_b  <= sh_b >> 1;
            nb_b  <= nb_b + 1'b1;
            if (nb_b == 4'd10) busy_b <= 1'b0;
        end
    end

    assign bus_a.tx_busy = busy_a;
    assign bus_b.tx_busy = busy_b;

    task automatic wait_en_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus_a.tx_enable) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_en_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus_b.tx_enable) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        bus_a.req_valid = '0; bus_a.req_data = '0;
        bus_b.req_valid = '0; bus_b.req_data = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus_a.req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", bus_a.req_ready); end
        checks++; if (bus_a.tx_enable !== 1'b0) begin errors++; $display("FAIL rst_tx_enable got %b want 0", bus_a.tx_enable); end
        checks++; if (bus_a.tx_data !== 9'h0) begin errors++; $display("FAIL rst_tx_data got %h want 0", bus_a.tx_data); end
        checks++; if (bus_a.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id got %0d want 0", bus_a.grant_id); end
        checks++; if (bus_a.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b want 0", bus_a.frame_done); end
        checks++; if (bus_a.tx_error !== 1'b0) begin errors++; $display("FAIL rst_tx_error got %b want 0", bus_a.tx_error); end
        checks++; if (bus_a.tx_baud_clk !== 1'b0) begin errors++; $display("FAIL rst_baud_clk got %b want 0", bus_a.tx_baud_clk); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [8:0] exp_d [5] = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h011};
        logic [3:0] exp_r [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bit ok;
        bus_a.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus_a.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_en_a(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_enable_timeout frame %0d got none want tx_enable", i); break; end
            checks++; if (bus_a.grant_id !== exp_g[i]) begin errors++; $display("FAIL rr_grant frame %0d got %0d want %0d", i, bus_a.grant_id, exp_g[i]); end
            checks++; if (bus_a.tx_data !== exp_d[i]) begin errors++; $display("FAIL rr_data frame %0d got %h want %h", i, bus_a.tx_data, exp_d[i]); end
            checks++; if (bus_a.req_ready !== exp_r[i]) begin errors++; $display("FAIL rr_ready frame %0d got %b want %b", i, bus_a.req_ready, exp_r[i]); end
        end
        bus_a.req_valid = '0;
        repeat (260) @(negedge clk);
    endtask

    task automatic test_single;
        bit ok, stable;
        int c;
        bus_a.req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus_a.req_valid = 4'b0100;
        wait_en_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_enable_timeout got none want tx_enable"); end
        checks++; if (bus_a.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", bus_a.req_ready); end
        checks++; if (bus_a.tx_data !== 9'h0A5) begin errors++; $display("FAIL single_data got %h want 0a5", bus_a.tx_data); end
        checks++; if (bus_a.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant got %0d want 2", bus_a.grant_id); end
        bus_a.req_valid = '0;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                checks++; if (bus_a.tx_enable !== 1'b0) begin errors++; $display("FAIL enable_width got %b want 0", bus_a.tx_enable); end
                checks++; if (bus_a.req_ready !== 4'b0) begin errors++; $display("FAIL ready_width got %b want 0", bus_a.req_ready); end
            end
            if (bus_a.tx_baud_clk) break;
        end
        checks++; if (c != 16) begin errors++; $display("FAIL first_tick got %0d cycles want 16", c); end
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c++;
            if (bus_a.tx_baud_clk) break;
        end
        checks++; if (c != 16) begin errors++; $display("FAIL baud_period got %0d cycles want 16", c); end
        ok = 1'b0; stable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_a.tx_data !== 9'h0A5 || bus_a.grant_id !== 2'd2) stable = 1'b0;
            if (bus_a.frame_done) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got none want frame_done"); end
        checks++; if (!stable) begin errors++; $display("FAIL single_stable got changed want held"); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL done_busy got %b want 0", busy_a); end
        checks++; if (cap_a !== 11'b10101001010) begin errors++; $display("FAIL serial_frame got %b want 10101001010", cap_a); end
        @(negedge clk);
        checks++; if (bus_a.frame_done !== 1'b0) begin errors++; $display("FAIL done_width got %b want 0", bus_a.frame_done); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_odd_parity_gap;
        bit ok;
        int ticks;
        bus_b.req_data  = {8'h00, 8'h00, 8'h03, 8'h07};
        bus_b.req_valid = 4'b0011;
        wait_en_b(ok);
        checks++; if (!ok) begin errors++; $display("FAIL odd_enable_timeout got none want tx_enable"); end
        checks++; if (bus_b.tx_data !== 9'h007) begin errors++; $display("FAIL odd_parity_07 got %h want 007", bus_b.tx_data); end
        checks++; if (bus_b.grant_id !== 2'd0) begin errors++; $display("FAIL odd_grant0 got %0d want 0", bus_b.grant_id); end
        bus_b.req_valid = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_b.frame_done) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL gap_done_timeout got none want frame_done"); end
        ok = 1'b0; ticks = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_b.tx_enable) begin ok = 1'b1; break; end
            if (bus_b.tx_baud_clk) ticks++;
        end
        checks++; if (!ok) begin errors++; $display("FAIL gap_enable_timeout got none want tx_enable"); end
        checks++; if (ticks < 2) begin errors++; $display("FAIL gap_ticks got %0d want >=2", ticks); end
        checks++; if (bus_b.tx_data !== 9'h103) begin errors++; $display("FAIL odd_parity_03 got %h want 103", bus_b.tx_data); end
        checks++; if (bus_b.grant_id !== 2'd1) begin errors++; $display("FAIL odd_grant1 got %0d want 1", bus_b.grant_id); end
        bus_b.req_valid = '0;
        repeat (260) @(negedge clk);
    endtask

    task automatic test_fault;
        bit ok, seen;
        int c;
        dead_a = 1'b1;
        bus_a.req_data  = {8'h5A, 8'h00, 8'h00, 8'h00};
        bus_a.req_valid = 4'b1000;
        wait_en_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fault_enable_timeout got none want tx_enable"); end
        checks++; if (bus_a.req_ready !== 4'b1000) begin errors++; $display("FAIL fault_ready got %b want 1000", bus_a.req_ready); end
        bus_a.req_valid = '0;
        c = 0; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            c++;
            if (bus_a.tx_error) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || c != 4) begin errors++; $display("FAIL error_delay got %0d cycles (seen=%0d) want 4", c, seen); end
        @(negedge clk);
        checks++; if (bus_a.tx_error !== 1'b0) begin errors++; $display("FAIL error_width got %b want 0", bus_a.tx_error); end
        checks++; if (bus_a.tx_enable !== 1'b0) begin errors++; $display("FAIL error_no_retry got %b want 0", bus_a.tx_enable); end
        dead_a = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok, seen_done;
        bus_a.req_data  = {8'h00, 8'h00, 8'hC3, 8'h00};
        bus_a.req_valid = 4'b0010;
        wait_en_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_enable_timeout got none want tx_enable"); end
        checks++; if (bus_a.grant_id !== 2'd1) begin errors++; $display("FAIL mid_grant got %0d want 1", bus_a.grant_id); end
        bus_a.req_valid = '0;
        repeat (40) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy_a); end
        reset = 1'b0;
        #1;
        checks++; if (bus_a.tx_data !== 9'h0) begin errors++; $display("FAIL mid_rst_data got %h want 0", bus_a.tx_data); end
        checks++; if (bus_a.grant_id !== 2'd0) begin errors++; $display("FAIL mid_rst_grant got %0d want 0", bus_a.grant_id); end
        checks++; if ({bus_a.req_ready, bus_a.tx_enable, bus_a.tx_baud_clk, bus_a.frame_done, bus_a.tx_error} !== 8'h0)
            begin errors++; $display("FAIL mid_rst_ctrl got %b want 0", {bus_a.req_ready, bus_a.tx_enable, bus_a.tx_baud_clk, bus_a.frame_done, bus_a.tx_error}); end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_a.frame_done) seen_done = 1'b1;
        end
        reset = 1'b1;
        bus_a.req_data  = {8'h00, 8'h99, 8'h00, 8'h3C};
        bus_a.req_valid = 4'b0101;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_a.frame_done) seen_done = 1'b1;
            if (bus_a.tx_enable) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL restart_enable_timeout got none want tx_enable"); end
        checks++; if (seen_done) begin errors++; $display("FAIL abandoned_done got pulse want none"); end
        checks++; if (bus_a.grant_id !== 2'd0) begin errors++; $display("FAIL restart_grant got %0d want 0", bus_a.grant_id); end
        checks++; if (bus_a.tx_data !== 9'h03C) begin errors++; $display("FAIL restart_data got %h want 03c", bus_a.tx_data); end
        bus_a.req_valid = '0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single;
        test_odd_parity_gap;
        test_fault;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
